// File: rtl/current_pkg.sv
// Shared constants and types for the current-sensor monitor path.
// The readout stage, monitor and register map all import these defaults.
package current_pkg;

  localparam int unsigned CUR_W        = 16;
  localparam int unsigned AVG_LOG2_DEF = 3;
  localparam int unsigned OC_COUNT_DEF = 3;
  localparam int unsigned OC_CNT_W     = 8;

  typedef enum logic {
    FILL,
    RUN
  } mon_state_t;

endpackage

// File: rtl/current_monitor_moving_avg.sv
// Power-of-two moving average over a ring buffer, with fill tracking
// so avg_valid only pulses once the window holds a full set of samples.
module moving_avg
  import current_pkg::*;
#(
  parameter int unsigned DATA_W   = CUR_W,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_valid_o,
  output logic              primed_o
);

  localparam int unsigned WIN   = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0]   ring_q [WIN];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [AVG_LOG2-1:0] wptr_q, wptr_d;
  logic [AVG_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  mon_state_t          state_q, state_d;
  logic                upd_q;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;

  // Unwritten slots are zero, so subtracting the evicted entry is exact during FILL too.
  always_comb begin
    sum_d  = sum_q;
    wptr_d = wptr_q;
    if (sample_valid_i) begin
      sum_d  = sum_q + SUM_W'(sample_i) - SUM_W'(ring_q[wptr_q]);
      wptr_d = wptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      FILL: begin
        if (sample_valid_i) begin
          if (fill_cnt_q == AVG_LOG2'(WIN - 1)) begin
            state_d = RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (upd_q) begin
      avg_d       = DATA_W'(sum_q >> AVG_LOG2);
      avg_valid_d = (state_q == RUN);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < WIN; i++) begin
        ring_q[i] <= '0;
      end
      sum_q       <= '0;
      wptr_q      <= '0;
      fill_cnt_q  <= '0;
      state_q     <= FILL;
      upd_q       <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      if (sample_valid_i) begin
        ring_q[wptr_q] <= sample_i;
      end
      sum_q       <= sum_d;
      wptr_q      <= wptr_d;
      fill_cnt_q  <= fill_cnt_d;
      state_q     <= state_d;
      upd_q       <= sample_valid_i;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign primed_o    = (state_q == RUN);

endmodule

// File: rtl/current_monitor.sv
// Current-sample monitor: moving average, peak hold and a latched
// over-current fault driven by a run of consecutive over-threshold samples.
module current_monitor
  import current_pkg::*;
#(
  parameter int unsigned DATA_W   = CUR_W,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned OC_COUNT = OC_COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] threshold,
  input  logic              clear_fault,
  input  logic              peak_clear,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              primed,
  output logic [DATA_W-1:0] peak_out,
  output logic              over_current
);

  localparam logic [OC_CNT_W-1:0] OC_MAX = OC_CNT_W'(OC_COUNT);

  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [OC_CNT_W-1:0] oc_cnt_q, oc_cnt_d;
  logic [OC_CNT_W-1:0] cnt_inc;
  logic                oc_q, oc_d;
  logic                hit;
  logic                trip;

  moving_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_moving_avg (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_i       (sample_in),
    .sample_valid_i (sample_valid),
    .avg_o          (avg_out),
    .avg_valid_o    (avg_valid),
    .primed_o       (primed)
  );

  always_comb begin
    peak_d = peak_q;
    if (peak_clear) begin
      peak_d = sample_valid ? sample_in : '0;
    end else if (sample_valid && (sample_in > peak_q)) begin
      peak_d = sample_in;
    end
  end

  // A trip on this sample outranks a coincident clear_fault.
  always_comb begin
    hit      = (sample_in > threshold);
    cnt_inc  = (oc_cnt_q == OC_MAX) ? OC_MAX : oc_cnt_q + 1'b1;
    trip     = 1'b0;
    oc_cnt_d = oc_cnt_q;
    oc_d     = oc_q;
    if (sample_valid) begin
      oc_cnt_d = hit ? cnt_inc : '0;
      trip     = hit && (cnt_inc == OC_MAX);
      oc_d     = trip | (oc_q & ~clear_fault);
    end else if (clear_fault) begin
      oc_cnt_d = '0;
      oc_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q   <= '0;
      oc_cnt_q <= '0;
      oc_q     <= 1'b0;
    end else begin
      peak_q   <= peak_d;
      oc_cnt_q <= oc_cnt_d;
      oc_q     <= oc_d;
    end
  end

  assign peak_out     = peak_q;
  assign over_current = oc_q;

endmodule

// File: tb/tb_current_monitor.sv
// Bench for current_monitor: directed literal checks plus randomized traffic
// compared every cycle against a window/history based reference model.
module tb_current_monitor;

  localparam int unsigned L   = 3;
  localparam int unsigned WIN = 8;
  localparam int unsigned OC  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] threshold;
  logic        clear_fault;
  logic        peak_clear;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        primed;
  logic [15:0] peak_out;
  logic        over_current;

  always #5 clk = ~clk;

  current_monitor #(
    .DATA_W   (16),
    .AVG_LOG2 (L),
    .OC_COUNT (OC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .threshold    (threshold),
    .clear_fault  (clear_fault),
    .peak_clear   (peak_clear),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .primed       (primed),
    .peak_out     (peak_out),
    .over_current (over_current)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of the last WIN samples, sample count, run length.
  int unsigned hist[$];
  int unsigned m_nsamp, m_pend_sum, m_avg, m_peak, m_run;
  bit          m_pend, m_pend_primed, m_avgv, m_primed, m_oc;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    int unsigned s;
    bit over, trip;
    if (!rst_n) begin
      hist.delete();
      m_nsamp = 0; m_pend_sum = 0; m_avg = 0; m_peak = 0; m_run = 0;
      m_pend = 0; m_pend_primed = 0; m_avgv = 0; m_primed = 0; m_oc = 0;
    end else begin
      m_avgv = m_pend && m_pend_primed;
      if (m_pend) m_avg = m_pend_sum >> L;
      m_pend = sample_valid;
      if (sample_valid) begin
        hist.push_back(int'(sample_in));
        if (hist.size() > WIN) void'(hist.pop_front());
        s = 0;
        foreach (hist[k]) s += hist[k];
        m_pend_sum = s;
        if (m_nsamp < WIN) m_nsamp++;
        m_pend_primed = (m_nsamp >= WIN);
      end
      m_primed = (m_nsamp >= WIN);

      if (peak_clear) m_peak = sample_valid ? int'(sample_in) : 0;
      else if (sample_valid && int'(sample_in) > m_peak) m_peak = int'(sample_in);

      if (sample_valid) begin
        over  = (sample_in > threshold);
        m_run = over ? ((m_run + 1 > OC) ? OC : m_run + 1) : 0;
        trip  = over && (m_run == OC);
        if (trip) m_oc = 1;
        else if (clear_fault) m_oc = 0;
      end else if (clear_fault) begin
        m_oc  = 0;
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("avg_out", avg_out, m_avg);
      chk("avg_valid", avg_valid, m_avgv);
      chk("primed", primed, m_primed);
      chk("peak_out", peak_out, m_peak);
      chk("over_current", over_current, m_oc);
    end
  end

  logic [15:0] a_avg, a_peak;
  logic        a_avgv, a_primed, a_oc;

  task automatic drive(input bit v, input int unsigned s, input bit cf, input bit pc);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s[15:0];
    clear_fault  = cf;
    peak_clear   = pc;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  // One sample, then capture the sample-edge outputs and the next-edge average.
  task automatic put(input int unsigned s, input bit cf, input bit pc);
    drive(1'b1, s, cf, pc);
    idle();
    a_peak = peak_out; a_oc = over_current; a_primed = primed;
    idle();
    a_avg = avg_out; a_avgv = avg_valid;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0; sample_valid = 1'b0; clear_fault = 1'b0; peak_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_avg"}, avg_out, 0);
    chk({tag, "_avgv"}, avg_valid, 0);
    chk({tag, "_primed"}, primed, 0);
    chk({tag, "_peak"}, peak_out, 0);
    chk({tag, "_oc"}, over_current, 0);
  endtask

  int unsigned zero_avg[8] = '{100, 87, 75, 62, 50, 37, 25, 0};
  int unsigned oc_seq[6]   = '{1001, 1001, 1000, 1001, 1001, 1001};

  initial begin
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
    threshold = 16'hFFFF; clear_fault = 1'b0; peak_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    model_on = 1'b1;

    for (int i = 0; i < 8; i++) begin
      put(100, 1'b0, 1'b0);
      chk("fill_avgv", a_avgv, (i == 7));
      chk("fill_primed", a_primed, (i == 7));
    end
    chk("fill_avg", a_avg, 100);
    chk("fill_peak", a_peak, 100);

    put(200, 1'b0, 1'b0);
    chk("step_avg", a_avg, 112);
    chk("step_avgv", a_avgv, 1);

    for (int i = 0; i < 8; i++) begin
      put(0, 1'b0, 1'b0);
      chk("drain_avg", a_avg, zero_avg[i]);
    end

    threshold = 16'd1000;
    for (int i = 0; i < 6; i++) begin
      put(oc_seq[i], 1'b0, 1'b0);
      chk("oc_trip", a_oc, (i == 5));
    end

    drive(1'b0, 0, 1'b1, 1'b0);
    idle();
    chk("oc_clear", over_current, 0);
    put(2000, 1'b0, 1'b0);
    chk("oc_run1", a_oc, 0);
    put(2000, 1'b0, 1'b0);
    chk("oc_run2", a_oc, 0);
    put(2000, 1'b1, 1'b0);
    chk("oc_trip_beats_clear", a_oc, 1);

    drive(1'b0, 0, 1'b0, 1'b1);
    idle();
    chk("peak_clear", peak_out, 0);
    put(300, 1'b0, 1'b0);
    put(700, 1'b0, 1'b0);
    put(200, 1'b0, 1'b0);
    chk("peak_hold", a_peak, 700);
    put(150, 1'b0, 1'b1);
    chk("peak_clear_load", a_peak, 150);

    reset_pulse();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) put(10, 1'b0, 1'b0);
    reset_pulse();
    chk_all_zero("midfill");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(50, 1'b0, 1'b0);
      chk("refill_avgv", a_avgv, (i == 7));
    end
    chk("refill_avg", a_avg, 50);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 299) != 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) threshold = 16'($urandom_range(950, 1050));
      if ($urandom_range(0, 3) == 0) sample_in = 16'($urandom_range(0, 65535));
      else sample_in = 16'($urandom_range(900, 1100));
      clear_fault  = ($urandom_range(0, 29) == 0);
      peak_clear   = ($urandom_range(0, 39) == 0);
    end
    rst_n = 1'b1;
    idle();
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
